lru_ctrl: RTL and testbench
===========================

# lru_ctrl

Sequencing controller for the L1 pseudo-LRU flag SRAM (3-bit tree per set, 4 ways). It arbitrates between L1 hit updates and fill victim requests, and runs a read-modify-write per request on a single-port SRAM. It returns the victim way for fills and initialises every set after reset. It sits between the L1 tag/hit pipeline, the fill unit and the LRU flag SRAM macro.

## Interface
Parameters:
- NUM_SETS, 64, number of L1 sets (power of two)
- SET_IDX_W, $clog2(NUM_SETS), set index width

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- fill_req_valid  in  1  fill needs a victim for fill_req_set
- fill_req_ready  out  1  fill request accepted this cycle
- fill_req_set  in  SET_IDX_W  fill set index
- fill_resp_valid  out  1  one-cycle pulse; victim is valid
- fill_resp_way  out  2  victim way
- fill_resp_set  out  SET_IDX_W  set of the victim
- hit_valid  in  1  L1 hit; promote hit_way in hit_set
- hit_ready  out  1  hit update accepted this cycle
- hit_set  in  SET_IDX_W  hit set index
- hit_way  in  2  way that hit
- sram_en  out  1  SRAM access enable
- sram_we  out  1  1 = write, 0 = read
- sram_addr  out  SET_IDX_W  SRAM address
- sram_wdata  out  3  flags to write
- sram_rdata  in  3  read data, valid the cycle after a read
- flush_req  in  1  (LRU_FLUSH_EN only) re-initialise all sets
- flush_busy  out  1  (LRU_FLUSH_EN only) init sweep in progress

## Operation
- Flags encoding: bit0 = a (left pair), bit1 = b (root), bit2 = c (right pair). A bit value of 0 points the victim to the lower-numbered side.
- Victim selection: if b = 0, way = a ? 1 : 0. Otherwise, way = c ? 3 : 2.
- Promotion on access of way w:
  - w in {0,1}: b = 1, a = (w == 0). c is unchanged.
  - w in {2,3}: b = 0, c = (w == 2). a is unchanged.
- Fill handling: compute the victim from the read flags, then promote the victim.
- FSM states: RST, INIT, IDLE, RD.
- RST:
  - Reset state.
  - All outputs are 0.
  - Moves unconditionally to INIT on the next clock.
- INIT:
  - Each cycle: sram_en = 1, sram_we = 1, sram_addr = init_cnt, sram_wdata = 0.
  - init_cnt counts 0 to NUM_SETS-1.
  - After the write to NUM_SETS-1, go to IDLE.
  - Both readies are 0.
- IDLE:
  - Readies are combinational from the grant.
  - On grant: sram_en = 1, sram_we = 0, sram_addr = the granted set. Latch the request type, set and way; go to RD.
  - With no request: sram_en = 0.
- RD:
  - sram_rdata is valid.
  - Drive sram_en = 1, sram_we = 1, same address, sram_wdata = promoted flags.
  - For a fill: fill_resp_valid = 1, with fill_resp_way and fill_resp_set.
  - Return to IDLE.
  - Both readies are 0.
- Arbitration uses a round-robin pointer rr (0 = fill, 1 = hit; reset 0).
  - Both requests valid: grant the side rr points to, then flip rr.
  - One request valid: grant it, and set rr to the other side.
- Requesters hold valid and payload until ready; payload is sampled on the handshake.
- There is no hazard logic: the single SRAM port serialises operations, so back-to-back requests to the same set see prior writes.

## Timing
- Request accepted in cycle t (valid & ready): SRAM read in t, write plus fill response in t+1, next grant no earlier than t+2.
- Throughput: one operation per 2 cycles.
- Post-reset: RST for 1 cycle, INIT for NUM_SETS cycles. The first ready is possible in cycle NUM_SETS+1 after rst_n deasserts.
- Reset asserted mid-operation, including RD: all outputs drop to 0 asynchronously, the pending write is lost, and the full INIT sequence reruns after release.
- fill_resp_* is not back-pressured; the consumer must accept it in the pulse cycle.

## Configuration
- LRU_FLUSH_EN defined:
  - Adds the flush_req and flush_busy ports.
  - flush_req sampled high in IDLE has priority over both requesters: no grant that cycle, go to INIT with init_cnt = 0.
  - flush_req high in RD: the RD write completes, then go to INIT.
  - flush_busy = 1 in RST/INIT, otherwise 0.
  - Reset value of flush_busy is 1.
- LRU_FLUSH_EN undefined:
  - The flush_req and flush_busy ports are absent.
  - INIT is entered only from RST.

## Test plan
- Reset release: exactly NUM_SETS (64) consecutive writes, addresses 0..63 with data 0, then both readies may assert; no SRAM access during RST.
- Four fills to set 5 from init: victims 0, 2, 1, 3; written flags 3'b011, 3'b101, 3'b110, 3'b000; each fill_resp one cycle after its handshake.
- Hit way 2 on set 7 (flags 0) writes 3'b100; a following fill on set 7 returns way 0 and writes 3'b111.
- fill_req_valid and hit_valid both high continuously: grants alternate fill, hit, fill, hit, starting with fill, one grant every 2 cycles, no starvation.
- rst_n pulsed low during RD: no write occurs for that request; 64-cycle INIT reruns; a subsequent fill on the same set returns way 0.
- With LRU_FLUSH_EN, flush_req pulsed in IDLE while fill_req_valid is high: fill_req_ready stays 0, flush_busy is high for 64 cycles, then the fill is granted and returns way 0.

Source files
------------

// File: rtl/lru_ctrl.sv
// Pseudo-LRU flag SRAM sequencer: arbitrates L1 hit promotions and fill victim requests.
// Optional LRU_FLUSH_EN adds flush_req/flush_busy for a software-triggered re-init sweep.
module lru_ctrl #(
   parameter int NUM_SETS  = 64,
   parameter int SET_IDX_W = $clog2(NUM_SETS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fill_req_valid,
   output logic                 fill_req_ready,
   input  logic [SET_IDX_W-1:0] fill_req_set,
   output logic                 fill_resp_valid,
   output logic [1:0]           fill_resp_way,
   output logic [SET_IDX_W-1:0] fill_resp_set,
   input  logic                 hit_valid,
   output logic                 hit_ready,
   input  logic [SET_IDX_W-1:0] hit_set,
   input  logic [1:0]           hit_way,
   output logic                 sram_en,
   output logic                 sram_we,
   output logic [SET_IDX_W-1:0] sram_addr,
   output logic [2:0]           sram_wdata,
   input  logic [2:0]           sram_rdata
`ifdef LRU_FLUSH_EN
   ,
   input  logic                 flush_req,
   output logic                 flush_busy
`endif
);

   typedef enum logic [1:0] {ST_RST, ST_INIT, ST_IDLE, ST_RD} state_t;

   state_t               state, state_nxt;
   logic [SET_IDX_W-1:0] init_cnt;
   logic                 rr;
   logic                 lat_fill;
   logic [SET_IDX_W-1:0] lat_set;
   logic [1:0]           lat_way;
   logic                 flush_go;
   logic                 gnt_fill, gnt_hit;
   logic [1:0]           vict_way, acc_way;
   logic [2:0]           new_flags;

`ifdef LRU_FLUSH_EN
   assign flush_go = flush_req;
`else
   assign flush_go = 1'b0;
`endif

   assign gnt_fill = (state == ST_IDLE) && !flush_go && fill_req_valid && (!hit_valid || !rr);
   assign gnt_hit  = (state == ST_IDLE) && !flush_go && hit_valid && (!fill_req_valid || rr);

   assign vict_way = sram_rdata[1] ? (sram_rdata[2] ? 2'd3 : 2'd2)
                                   : (sram_rdata[0] ? 2'd1 : 2'd0);
   assign acc_way  = lat_fill ? vict_way : lat_way;
   assign new_flags = acc_way[1] ? {~acc_way[0], 1'b0, sram_rdata[0]}
                                 : {sram_rdata[2], 1'b1, ~acc_way[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RST;
         init_cnt <= '0;
         rr       <= 1'b0;
         lat_fill <= 1'b0;
         lat_set  <= '0;
         lat_way  <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= (state == ST_INIT) ? init_cnt + 1'b1 : '0;
         if (gnt_fill || gnt_hit) begin
            // Any grant leaves rr pointing away from the fill side iff fill won.
            rr       <= gnt_fill;
            lat_fill <= gnt_fill;
            lat_set  <= gnt_fill ? fill_req_set : hit_set;
            lat_way  <= hit_way;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RST:  state_nxt = ST_INIT;
         ST_INIT: if (init_cnt == SET_IDX_W'(NUM_SETS - 1)) state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (flush_go)                state_nxt = ST_INIT;
            else if (gnt_fill || gnt_hit) state_nxt = ST_RD;
         end
         ST_RD:   state_nxt = flush_go ? ST_INIT : ST_IDLE;
         default: state_nxt = ST_RST;
      endcase
   end

   always_comb begin
      fill_req_ready  = 1'b0;
      hit_ready       = 1'b0;
      fill_resp_valid = 1'b0;
      fill_resp_way   = '0;
      fill_resp_set   = '0;
      sram_en         = 1'b0;
      sram_we         = 1'b0;
      sram_addr       = '0;
      sram_wdata      = '0;
`ifdef LRU_FLUSH_EN
      flush_busy      = (state == ST_RST) || (state == ST_INIT);
`endif
      case (state)
         ST_INIT: begin
            sram_en   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = init_cnt;
         end
         ST_IDLE: begin
            fill_req_ready = gnt_fill;
            hit_ready      = gnt_hit;
            if (gnt_fill || gnt_hit) begin
               sram_en   = 1'b1;
               sram_addr = gnt_fill ? fill_req_set : hit_set;
            end
         end
         ST_RD: begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = lat_set;
            sram_wdata = new_flags;
            if (lat_fill) begin
               fill_resp_valid = 1'b1;
               fill_resp_way   = vict_way;
               fill_resp_set   = lat_set;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lru_ctrl.sv
// Directed self-checking bench for lru_ctrl with a behavioural flag SRAM.
// Flush scenario is built only when LRU_FLUSH_EN is defined.
module tb_lru_ctrl;

   localparam int NUM_SETS  = 64;
   localparam int SET_IDX_W = 6;

   logic                 clk;
   logic                 rst_n;
   logic                 fill_req_valid, fill_req_ready;
   logic [SET_IDX_W-1:0] fill_req_set;
   logic                 fill_resp_valid;
   logic [1:0]           fill_resp_way;
   logic [SET_IDX_W-1:0] fill_resp_set;
   logic                 hit_valid, hit_ready;
   logic [SET_IDX_W-1:0] hit_set;
   logic [1:0]           hit_way;
   logic                 sram_en, sram_we;
   logic [SET_IDX_W-1:0] sram_addr;
   logic [2:0]           sram_wdata, sram_rdata;
`ifdef LRU_FLUSH_EN
   logic                 flush_req, flush_busy;
`endif

   int checks   = 0;
   int failures = 0;

   logic [2:0] mem [NUM_SETS];

   lru_ctrl #(.NUM_SETS(NUM_SETS), .SET_IDX_W(SET_IDX_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
      .fill_req_set(fill_req_set),
      .fill_resp_valid(fill_resp_valid), .fill_resp_way(fill_resp_way),
      .fill_resp_set(fill_resp_set),
      .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_set(hit_set), .hit_way(hit_way),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef LRU_FLUSH_EN
      , .flush_req(flush_req), .flush_busy(flush_busy)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we) mem[sram_addr] <= sram_wdata;
         else         sram_rdata     <= mem[sram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after rst_n release; ends at the negedge of the first IDLE cycle.
   task automatic check_init_seq(input string tag);
      @(negedge clk);
      check({tag, "_rst_idle"}, {sram_en, fill_req_ready, hit_ready}, 3'b000);
      for (int i = 0; i < NUM_SETS; i++) begin
         @(negedge clk);
         check({tag, "_init"}, {fill_req_ready, hit_ready, sram_en, sram_we, sram_addr, sram_wdata},
               {1'b0, 1'b0, 1'b1, 1'b1, 6'(i), 3'b000});
      end
      @(negedge clk);
      check({tag, "_idle"}, {sram_en, sram_we}, 2'b00);
   endtask

   // Starts and ends at a negedge; checks the RD-cycle write and fill response.
   task automatic do_req(input string tag, input logic is_fill, input logic [5:0] set,
                         input logic [1:0] way, input logic [1:0] exp_way, input logic [2:0] exp_wd);
      int n;
      if (is_fill) begin
         fill_req_valid = 1'b1; fill_req_set = set;
      end else begin
         hit_valid = 1'b1; hit_set = set; hit_way = way;
      end
      n = 0;
      #1;
      while (!(is_fill ? fill_req_ready : hit_ready) && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         check({tag, "_timeout"}, 32'(n), 32'd0);
      end else begin
         check({tag, "_rd"}, {sram_en, sram_we, sram_addr}, {1'b1, 1'b0, set});
         @(posedge clk); #1;
         fill_req_valid = 1'b0; hit_valid = 1'b0;
         @(negedge clk);
         check({tag, "_wr"}, {fill_req_ready, hit_ready, sram_en, sram_we, sram_addr, sram_wdata},
               {1'b0, 1'b0, 1'b1, 1'b1, set, exp_wd});
         if (is_fill)
            check({tag, "_resp"}, {fill_resp_valid, fill_resp_way, fill_resp_set}, {1'b1, exp_way, set});
         else
            check({tag, "_noresp"}, {31'd0, fill_resp_valid}, 32'd0);
      end
   endtask

   logic [2:0] arb_exp [8];

   initial begin
      rst_n = 1'b0;
      fill_req_valid = 1'b0; fill_req_set = '0;
      hit_valid = 1'b0; hit_set = '0; hit_way = '0;
`ifdef LRU_FLUSH_EN
      flush_req = 1'b0;
`endif
      @(posedge clk); @(posedge clk); #1;
      check("reset_outs", {sram_en, sram_we, fill_req_ready, hit_ready, fill_resp_valid}, 5'b0);
`ifdef LRU_FLUSH_EN
      check("reset_busy", {31'd0, flush_busy}, 32'd1);
`endif
      rst_n = 1'b1;
      check_init_seq("boot");

      // Both requesters held high: fill, hit, fill, hit with a grant every second cycle.
      arb_exp[0] = 3'b100; arb_exp[1] = 3'b001; arb_exp[2] = 3'b010; arb_exp[3] = 3'b000;
      arb_exp[4] = 3'b100; arb_exp[5] = 3'b001; arb_exp[6] = 3'b010; arb_exp[7] = 3'b000;
      fill_req_valid = 1'b1; fill_req_set = 6'd20;
      hit_valid = 1'b1; hit_set = 6'd21; hit_way = 2'd3;
      for (int c = 0; c < 8; c++) begin
         #1;
         check("arb_seq", {fill_req_ready, hit_ready, fill_resp_valid}, arb_exp[c]);
         if (c == 1) check("arb_way0", {30'd0, fill_resp_way}, 32'd0);
         if (c == 5) check("arb_way1", {30'd0, fill_resp_way}, 32'd2);
         @(negedge clk);
      end
      fill_req_valid = 1'b0; hit_valid = 1'b0;

      do_req("fill5_a", 1'b1, 6'd5, 2'd0, 2'd0, 3'b011);
      do_req("fill5_b", 1'b1, 6'd5, 2'd0, 2'd2, 3'b101);
      do_req("fill5_c", 1'b1, 6'd5, 2'd0, 2'd1, 3'b110);
      do_req("fill5_d", 1'b1, 6'd5, 2'd0, 2'd3, 3'b000);
      do_req("hit7",    1'b0, 6'd7, 2'd2, 2'd0, 3'b100);
      do_req("fill7",   1'b1, 6'd7, 2'd0, 2'd0, 3'b111);
      do_req("fill7_b", 1'b1, 6'd7, 2'd0, 2'd3, 3'b001);

      // Fill on set 7 caught in RD by reset: write must not happen.
      @(negedge clk);
      fill_req_valid = 1'b1; fill_req_set = 6'd7;
      #1;
      check("rdrst_gnt", {31'd0, fill_req_ready}, 32'd1);
      @(posedge clk); #1;
      fill_req_valid = 1'b0;
      check("rdrst_in_rd", {sram_en, sram_we}, 2'b11);
      rst_n = 1'b0;
      #1;
      check("rdrst_outs", {sram_en, sram_we, fill_resp_valid, fill_req_ready, hit_ready}, 5'b0);
      @(posedge clk); #1;
      check("rdrst_held", {sram_en, sram_we}, 2'b00);
      check("rdrst_nowr", {29'd0, mem[7]}, 32'b001);
      rst_n = 1'b1;
      check_init_seq("rerun");
      do_req("fill7_post", 1'b1, 6'd7, 2'd0, 2'd0, 3'b011);

`ifdef LRU_FLUSH_EN
      @(negedge clk);
      fill_req_valid = 1'b1; fill_req_set = 6'd7;
      flush_req = 1'b1;
      #1;
      check("flush_block", {30'd0, flush_busy, fill_req_ready}, 32'b00);
      @(posedge clk); #1;
      flush_req = 1'b0;
      for (int i = 0; i < NUM_SETS; i++) begin
         @(negedge clk);
         check("flush_busy", {30'd0, flush_busy, fill_req_ready}, 32'b10);
      end
      @(negedge clk);
      check("flush_done", {31'd0, flush_busy}, 32'd0);
      do_req("fill7_flush", 1'b1, 6'd7, 2'd0, 2'd0, 3'b011);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
